// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Wishbone memory port between the I-cache and
// D-cache controllers. The granted master's strobes, address and write data
// are steered to memory; ack/rty return only to that master.
// Optional build macro ARB_ROUND_ROBIN_EN: on simultaneous requests, grant
// the master that did not win last time. When undefined, ties go to the D-cache.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ack,
  output logic              i_rty,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rty,
  output logic [DATA_W-1:0] d_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cyc,
  output logic              mem_stb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rty,
  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;   // 1 when the D-cache completed the last transfer
  logic   i_req, d_req;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

  // Read data is broadcast; only the granted master sees an ack for it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State and last-grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Arbitration, exit conditions and combinational steering
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    mem_cyc    = 1'b0;
    mem_stb    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_ack      = 1'b0;
    i_rty      = 1'b0;
    d_ack      = 1'b0;
    d_rty      = 1'b0;
    grant_d    = (state == GNT_D);
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = last_d ? GNT_I : GNT_D;
`else
          state_nxt = GNT_D;
`endif
        end else if (d_req) begin
          state_nxt = GNT_D;
        end else if (i_req) begin
          state_nxt = GNT_I;
        end
      end

      GNT_I: begin
        mem_cyc   = i_cyc;
        mem_stb   = i_stb;
        mem_we    = i_we;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ack     = mem_ack;
        i_rty     = mem_rty & ~mem_ack;
        if (mem_ack || mem_rty) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b0;
        end else if (!i_cyc) begin
          state_nxt = IDLE;
        end
      end

      GNT_D: begin
        mem_cyc   = d_cyc;
        mem_stb   = d_stb;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ack     = mem_ack;
        d_rty     = mem_rty & ~mem_ack;
        if (mem_ack || mem_rty) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b1;
        end else if (!d_cyc) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter. Inputs change on the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Expected tie-break results follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cyc, i_stb, i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ack, i_rty;
  logic [DATA_W-1:0] i_rdata;
  logic              d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack, d_rty;
  logic [DATA_W-1:0] d_rdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_cyc, mem_stb, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack, mem_rty;
  logic              grant_d, busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DATA_W-1:0] aa_line;
  logic [DATA_W-1:0] i_line;
  logic [DATA_W-1:0] rd_line;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_rty(i_rty), .i_rdata(i_rdata),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rty(d_rty), .d_rdata(d_rdata),
    .mem_rdata(mem_rdata),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rty(mem_rty),
    .grant_d(grant_d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one full cycle, landing on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_cyc = 0; i_stb = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rty = 0;
  endtask

  // All strobes, acks, status and buses at their idle values.
  task automatic check_idle(input string tag);
    check({tag, ".ctl"},
          DATA_W'({mem_cyc, mem_stb, mem_we, i_ack, i_rty, d_ack, d_rty, grant_d, busy}),
          DATA_W'(0));
    check({tag, ".addr"}, DATA_W'(mem_addr), DATA_W'(0));
    check({tag, ".wdata"}, mem_wdata, DATA_W'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    aa_line   = {32{8'hAA}};
    i_line    = {32{8'h5C}};
    rd_line   = {8{32'hDEAD_BEEF}};
    mem_rdata = rd_line;
    rst = 1;
    clear_inputs();

    // Reset state
    do_reset();
    settle();
    check_idle("reset");
    check("rdata_fanout", {i_rdata ^ d_rdata}, DATA_W'(0));
    check("rdata_value", d_rdata, rd_line);

    // Single I read, ack on third granted cycle
    i_cyc = 1; i_stb = 1; i_addr = 32'h100;
    settle();
    check("i1.idle_busy", DATA_W'(busy), DATA_W'(0));
    step(); settle();
    check("i1.addr", DATA_W'(mem_addr), DATA_W'(32'h100));
    check("i1.ctl1", DATA_W'({mem_cyc, mem_stb, mem_we, busy, grant_d, i_ack}), DATA_W'(6'b110100));
    step(); settle();
    check("i1.ctl2", DATA_W'({mem_cyc, busy, i_ack}), DATA_W'(3'b110));
    step();
    mem_ack = 1; settle();
    check("i1.ack", DATA_W'({i_ack, i_rty, d_ack, d_rty}), DATA_W'(4'b1000));
    step();
    clear_inputs(); settle();
    check_idle("i1.after");
    step();

    // Tie after reset
    do_reset();
    i_cyc = 1; i_stb = 1; i_addr = 32'h180;
    d_cyc = 1; d_stb = 1; d_addr = 32'h1C0;
    step(); settle();
    check("tie.first_d", DATA_W'({grant_d, busy}), DATA_W'(2'b11));
    check("tie.addr_d", DATA_W'(mem_addr), DATA_W'(32'h1C0));
    mem_ack = 1; settle();
    check("tie.d_ack", DATA_W'({d_ack, i_ack}), DATA_W'(2'b10));
    step();
    mem_ack = 0; settle();
    check("tie.gap", DATA_W'(busy), DATA_W'(0));
    step(); settle();
`ifdef ARB_ROUND_ROBIN_EN
    check("tie.second", DATA_W'({grant_d, busy}), DATA_W'(2'b01));
    check("tie.second_addr", DATA_W'(mem_addr), DATA_W'(32'h180));
`else
    check("tie.second", DATA_W'({grant_d, busy}), DATA_W'(2'b11));
    check("tie.second_addr", DATA_W'(mem_addr), DATA_W'(32'h1C0));
`endif
    mem_ack = 1; step();
    clear_inputs(); step();

    // D write-back then allocate read
    d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 32'h200; d_wdata = aa_line;
    i_wdata = i_line;
    step(); settle();
    check("wb.we", DATA_W'({mem_we, mem_cyc, grant_d}), DATA_W'(3'b111));
    check("wb.wdata", mem_wdata, aa_line);
    mem_ack = 1; settle();
    check("wb.ack", DATA_W'({d_ack, i_ack}), DATA_W'(2'b10));
    step();
    mem_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    step();
    d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h240;
    step(); settle();
    check("alloc.we", DATA_W'({mem_we, mem_cyc}), DATA_W'(2'b01));
    check("alloc.addr", DATA_W'(mem_addr), DATA_W'(32'h240));
    mem_ack = 1; settle();
    check("alloc.ack", DATA_W'({d_ack, i_ack}), DATA_W'(2'b10));
    step();
    clear_inputs(); step();

    // Retry on I, re-granted while still requesting
    i_cyc = 1; i_stb = 1; i_addr = 32'h300;
    step();
    mem_rty = 1; settle();
    check("rty.resp", DATA_W'({i_rty, i_ack, d_rty}), DATA_W'(3'b100));
    step();
    mem_rty = 0; settle();
    check("rty.gap", DATA_W'(busy), DATA_W'(0));
    step(); settle();
    check("rty.regrant", DATA_W'({busy, grant_d, mem_cyc}), DATA_W'(3'b101));
    check("rty.addr", DATA_W'(mem_addr), DATA_W'(32'h300));
    mem_ack = 1; step();
    clear_inputs(); step();

    // Reset mid-transfer with mem_ack high
    d_cyc = 1; d_stb = 1; d_addr = 32'h400;
    step();
    mem_ack = 1; rst = 1; settle();
    check("rstmid.pre", DATA_W'(d_ack), DATA_W'(1));
    step();
    rst = 0; mem_ack = 0; d_cyc = 0; d_stb = 0; d_addr = '0; settle();
    check_idle("rstmid");
    step();

    // Abandon keeps last_grant: D completes, then I abandons, then tie
    d_cyc = 1; d_stb = 1; d_addr = 32'h500;
    step();
    mem_ack = 1; step();
    clear_inputs();
    i_cyc = 1; i_stb = 1; i_addr = 32'h540;
    step(); settle();
    check("abn.gnt_i", DATA_W'({busy, grant_d}), DATA_W'(2'b10));
    i_cyc = 0; i_stb = 0;
    step(); settle();
    check("abn.idle", DATA_W'(busy), DATA_W'(0));
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    step(); settle();
`ifdef ARB_ROUND_ROBIN_EN
    check("abn.tie", DATA_W'(grant_d), DATA_W'(0));
`else
    check("abn.tie", DATA_W'(grant_d), DATA_W'(1));
`endif
    mem_ack = 1; step();
    clear_inputs(); step();

    // Stray ack in IDLE, then ack+rty together in GNT_D
    mem_ack = 1; settle();
    check("stray.acks", DATA_W'({i_ack, i_rty, d_ack, d_rty, busy}), DATA_W'(0));
    step();
    mem_ack = 0; settle();
    check("stray.still_idle", DATA_W'(busy), DATA_W'(0));
    d_cyc = 1; d_stb = 1; d_addr = 32'h600;
    step();
    mem_ack = 1; mem_rty = 1; settle();
    check("both.resp", DATA_W'({d_ack, d_rty, i_ack, i_rty}), DATA_W'(4'b1000));
    step();
    clear_inputs(); settle();
    check("both.exit", DATA_W'(busy), DATA_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single physical-memory Wishbone port between the instruction-cache and data-cache controllers. Each cache controller drives its own cyc/stb/we request; the arbiter grants one of them, steers address, write data and strobes to memory, and returns ack/rty only to the granted master. It sits between the two cache_control-style controllers and the physical memory model.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 256, cache-line data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_cyc, i_stb, i_we  in  1 each  I-cache request strobes
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write data
- i_ack, i_rty  out  1 each  I-cache completion / retry
- d_cyc, d_stb, d_we  in  1 each  D-cache request strobes
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  D-cache write data
- d_ack, d_rty  out  1 each  D-cache completion / retry
- mem_rdata  in  DATA_W  memory read data, fanned out unmodified to both masters
- mem_cyc, mem_stb, mem_we  out  1 each  memory strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack, mem_rty  in  1 each  memory completion / retry
- grant_d  out  1  1 while D-cache owns the port (status)
- busy  out  1  1 while any master owns the port

## Operation
- Request: master X requests when X_cyc & X_stb.
- States: IDLE, GNT_I, GNT_D. Reset -> IDLE; last_grant register <- I.
- IDLE: no memory strobes. If one master requests -> grant it. If both request -> arbitration rule (see Configuration). No request -> stay.
- GNT_X: mem_cyc/stb/we/addr/wdata = X's signals combinationally; X_ack = mem_ack, X_rty = mem_rty; other master's ack/rty held 0.
- GNT_X exit: on mem_ack or mem_rty -> IDLE next cycle, last_grant <- X. If X drops cyc (abandons transfer) -> IDLE, last_grant unchanged.
- In IDLE: mem_addr/mem_wdata = 0, mem_cyc/stb/we = 0, all acks/rtys = 0.
- mem_ack or mem_rty arriving in IDLE: ignored, not forwarded.
- grant_d = (state==GNT_D); busy = (state!=IDLE).

## Timing
- Reset values: mem_cyc=mem_stb=mem_we=0, mem_addr=0, mem_wdata=0, i_ack=i_rty=d_ack=d_rty=0, grant_d=0, busy=0.
- Grant latency: request sampled in IDLE at edge N; memory strobes asserted in cycle N+1.
- Ack/rty path: combinational, zero added latency, memory -> granted master.
- One mandatory IDLE cycle after every ack/rty; back-to-back transfers from the same master are separated by one cycle, which gives the losing master a chance to win.
- Master holding stb high after its ack re-arbitrates in that IDLE cycle.
- Simultaneous mem_ack and mem_rty: ack wins; only X_ack asserted.
- rst asserted mid-transfer: state -> IDLE and all outputs to reset values at next edge, regardless of mem_ack; last_grant <- I.
- Granted master's signals must stay stable until ack; the arbiter does not register them.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the master that was not last_grant. After reset (last_grant=I), the D-cache wins first.
- Not defined: fixed priority, D-cache always wins ties. last_grant is still maintained but does not affect arbitration.

## Test plan
- Single I read: i_cyc=i_stb=1, i_we=0, i_addr=0x100; mem_ack on the 3rd granted cycle -> mem_addr=0x100 from the cycle after the request, i_ack pulses with mem_ack, d_ack=0, busy returns to 0 the next cycle.
- Tie after reset: both request at once -> GNT_D first; D ack -> IDLE; with ARB_ROUND_ROBIN_EN the I-cache is granted next, without it the D-cache is granted again while D still requests.
- D write-back then allocate: d_we=1, d_wdata=0xAA..AA, ack; d_cyc low 1 cycle; d_we=0 read -> mem_we=1 then mem_we=0, mem_wdata matches, i_ack stays 0 throughout.
- Retry: mem_rty=1 during GNT_I -> i_rty=1 for that cycle, i_ack=0, state IDLE next cycle, I re-granted when still requesting.
- Reset mid-transfer: rst=1 in GNT_D while mem_ack=1 -> next cycle all outputs 0, state IDLE, D ack not remembered.
- Stray memory ack in IDLE and simultaneous mem_ack+mem_rty in GNT_D -> the stray ack produces no master ack; the simultaneous case gives d_ack=1, d_rty=0.
